// File: rtl/cordic_pkg.sv
// Shared encodings and angle constants for the CORDIC phase driver.
package cordic_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] ANGLE_HALF_PI = 16'h4000;
    localparam logic [DATA_W-1:0] ANGLE_PI      = 16'h8000;
    localparam logic [DATA_W-1:0] SAT_POS       = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG       = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Two's complement negation that maps the most negative value to the most positive.
    function automatic logic [DATA_W-1:0] sat_negate(input logic [DATA_W-1:0] y);
        if (y == SAT_NEG) begin
            return SAT_POS;
        end
        return DATA_W'(DATA_W'(0) - y);
    endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a full-circle unsigned phase into the core's +/- pi/2 range plus an output-negate flag.
module cordic_quadrant_fold
    import cordic_pkg::*;
(
    input  logic [DATA_W-1:0] phase,
    output logic [DATA_W-1:0] z_c,
    output logic              neg_c
);

    logic [DATA_W-1:0] lo_ext;

    assign lo_ext = {2'b00, phase[DATA_W-3:0]};

    always_comb begin
        z_c   = lo_ext;
        neg_c = 1'b0;
        unique case (phase[DATA_W-1:DATA_W-2])
            2'd0: z_c = lo_ext;
            2'd1: z_c = DATA_W'(ANGLE_HALF_PI - lo_ext);
            2'd2: begin
                z_c   = lo_ext;
                neg_c = 1'b1;
            end
            2'd3: z_c = DATA_W'(lo_ext - ANGLE_HALF_PI);
            default: z_c = lo_ext;
        endcase
    end

endmodule

// File: rtl/cordic_phase_driver.sv
// Phase accumulator and launch/capture sequencer feeding the CORDIC core of the sine generator.
module cordic_phase_driver
    import cordic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] freq_word,
    output logic [DATA_W-1:0] cordic_z,
    output logic              cordic_en,
    input  logic              cordic_done,
    input  logic [DATA_W-1:0] cordic_y,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] phase_q, phase_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic              neg_q, neg_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] phase_sum_c;
    logic [DATA_W-1:0] fold_phase_c;
    logic [DATA_W-1:0] fold_z_c;
    logic              fold_neg_c;

    // A relaunch from HOLD must fold the already-advanced phase.
    assign phase_sum_c  = DATA_W'(phase_q + freq_word);
    assign fold_phase_c = (state_q == ST_HOLD) ? phase_sum_c : phase_q;

    cordic_quadrant_fold u_fold (
        .phase (fold_phase_c),
        .z_c   (fold_z_c),
        .neg_c (fold_neg_c)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        z_d      = z_q;
        neg_d    = neg_q;
        en_d     = 1'b0;
        sample_d = sample_q;
        valid_d  = valid_q;
        error_d  = error_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                    z_d     = fold_z_c;
                    neg_d   = fold_neg_c;
                    en_d    = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cordic_done) begin
                    sample_d = neg_q ? sat_negate(cordic_y) : cordic_y;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (valid_q && sample_ready) begin
                    valid_d = 1'b0;
                    phase_d = phase_sum_c;
                    if (start) begin
                        state_d = ST_LAUNCH;
                        z_d     = fold_z_c;
                        neg_d   = fold_neg_c;
                        en_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            z_q      <= '0;
            neg_q    <= 1'b0;
            en_q     <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            z_q      <= z_d;
            neg_q    <= neg_d;
            en_q     <= en_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cordic_z     = z_q;
    assign cordic_en    = en_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule
